// File: rtl/hamming_ecc_top_if.sv
// Bundles the encoder/decoder data path: the word and injection requests in,
// the decoded word, error flags and debug codeword out.
interface hamming_ecc_top_if;
  logic [31:0] data;
  logic        inject_error;
  logic        inject_double;
  logic [31:0] dec_data;
  logic        single_err;
  logic        double_err;
  logic [38:0] codeword;

  // No valid/ready pair: a new word is accepted on every rising clk edge and
  // its result appears on the outputs exactly two edges later, with no stalls.
  modport master (
    output data, inject_error, inject_double,
    input  dec_data, single_err, double_err, codeword
  );

  modport slave (
    input  data, inject_error, inject_double,
    output dec_data, single_err, double_err, codeword
  );
endinterface

// File: rtl/hamming_ecc_top.sv
// Two-stage SECDED Hamming(39,32): stage 1 encodes and applies error injection,
// stage 2 computes syndrome/parity, corrects single errors and flags doubles.
module hamming_ecc_top #(
  parameter int INJECT_POS  = 5,
  parameter int INJECT_POS2 = 9
) (
  input logic              clk,
  input logic              rst_n,
  hamming_ecc_top_if.slave bus
);

  localparam logic [38:0] MASK1 = 39'(1) << INJECT_POS;
  localparam logic [38:0] MASK2 = 39'(1) << INJECT_POS2;

  // Data fills non-power-of-two positions; parity bit 2^k covers indices with bit k set.
  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [38:0] cw;
    int          j;
    logic        par;
    cw = '0;
    j  = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int p = 1; p < 39; p++) begin
        if (((p >> k) & 1) == 1) par = par ^ cw[p];
      end
      cw[1 << k] = par;
    end
    cw[0] = ^cw[38:1];
    return cw;
  endfunction

  function automatic logic [31:0] extract(input logic [38:0] cw);
    logic [31:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p];
        j++;
      end
    end
    return d;
  endfunction

  logic [38:0] mask;
  logic [38:0] cw_q;
  logic [5:0]  syndrome;
  logic        parity;
  logic [38:0] fixed;
  logic        single_d;
  logic        double_d;
  logic [31:0] dec_q;
  logic        single_q;
  logic        double_q;

  always_comb begin
    mask = '0;
    if (bus.inject_error) begin
      mask = MASK1;
      if (bus.inject_double) mask = mask | MASK2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cw_q <= '0;
    else        cw_q <= encode(bus.data) ^ mask;
  end

  always_comb begin
    syndrome = '0;
    for (int p = 1; p < 39; p++) begin
      if (cw_q[p]) syndrome = syndrome ^ 6'(p);
    end
    parity   = ^cw_q;
    fixed    = cw_q;
    single_d = 1'b0;
    double_d = 1'b0;
    if (syndrome == 6'd0) begin
      // Only bit 0 can be wrong here; the data positions are intact.
      single_d = parity;
    end else if (parity && syndrome <= 6'd38) begin
      fixed[syndrome] = ~cw_q[syndrome];
      single_d        = 1'b1;
    end else begin
      double_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
    end else begin
      dec_q    <= extract(fixed);
      single_q <= single_d;
      double_q <= double_d;
    end
  end

  assign bus.codeword   = cw_q;
  assign bus.dec_data   = dec_q;
  assign bus.single_err = single_q;
  assign bus.double_err = double_q;

endmodule

// File: tb/tb_hamming_ecc_top.sv
// Bench for hamming_ecc_top: directed and random words against a reference
// model, mid-stream reset, and a sweep of the single-error position.
module tb_hamming_ecc_top;

  localparam int P1 = 5;
  localparam int P2 = 9;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hamming_ecc_top_if bus ();
  hamming_ecc_top #(.INJECT_POS(P1), .INJECT_POS2(P2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Sweep instances: one per injection position 0..38, all injecting a single error.
  logic [31:0] sweep_data;
  logic [31:0] sweep_dec    [39];
  logic        sweep_single [39];
  logic        sweep_double [39];

  for (genvar g = 0; g < 39; g++) begin : g_sweep
    hamming_ecc_top_if sif ();
    assign sif.data          = sweep_data;
    assign sif.inject_error  = 1'b1;
    assign sif.inject_double = 1'b0;
    hamming_ecc_top #(.INJECT_POS(g), .INJECT_POS2((g == 9) ? 5 : 9)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
    );
    assign sweep_dec[g]    = sif.dec_data;
    assign sweep_single[g] = sif.single_err;
    assign sweep_double[g] = sif.double_err;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];
  int dpos[32];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: XOR of the indices of set data positions gives the parity bits directly.
  function automatic logic [38:0] model_encode(input logic [31:0] d);
    logic [38:0] cw;
    int          v;
    cw = '0;
    v  = 0;
    for (int j = 0; j < 32; j++) begin
      if (d[j]) begin
        cw[dpos[j]] = 1'b1;
        v = v ^ dpos[j];
      end
    end
    for (int k = 0; k < 6; k++) cw[1 << k] = ((v >> k) & 1) == 1;
    cw[0] = ^cw[38:1];
    return cw;
  endfunction

  function automatic logic [38:0] model_mask(input logic ie, input logic id);
    logic [38:0] m;
    m = '0;
    if (ie) begin
      m[P1] = 1'b1;
      if (id) m[P2] = 1'b1;
    end
    return m;
  endfunction

  // Expected {double_err, single_err, dec_data} from what was injected.
  function automatic logic [33:0] model_out(input logic [31:0] d, input logic ie, input logic id);
    logic [31:0] dx;
    if (!ie) return {2'b00, d};
    if (!id) return {2'b01, d};
    dx = d;
    for (int j = 0; j < 32; j++) begin
      if (dpos[j] == P1 || dpos[j] == P2) dx[j] = ~dx[j];
    end
    return {2'b10, dx};
  endfunction

  // driver: apply a word, advance one edge, check codeword and the word from two edges back
  task automatic step(input logic [31:0] d, input logic ie, input logic id);
    logic [33:0] got;
    bus.data          = d;
    bus.inject_error  = ie;
    bus.inject_double = id;
    exp_q.push_back(model_out(d, ie, id));
    @(negedge clk);
    check_eq("codeword", 64'(bus.codeword), 64'(model_encode(d) ^ model_mask(ie, id)));
    got = {bus.double_err, bus.single_err, bus.dec_data};
    check_eq("outputs", 64'(got), 64'(exp_q.pop_front()));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 64'({bus.codeword, bus.dec_data, bus.single_err, bus.double_err}), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int pos;
    logic [31:0] d;
    pos = 1;
    for (int j = 0; j < 32; j++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
      dpos[j] = pos;
    end

    bus.data          = '0;
    bus.inject_error  = 1'b0;
    bus.inject_double = 1'b0;
    sweep_data        = '0;

    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(34'd0);

    // data=4 with and without a single injection
    step(32'd4, 1'b0, 1'b0);
    check_eq("cw_data4", 64'(bus.codeword), 64'h55);
    step(32'd4, 1'b1, 1'b0);
    check_eq("cw_data4_inj", 64'(bus.codeword), 64'h75);
    // inject toggled 0/1/0 on a constant word
    step(32'd8456, 1'b0, 1'b0);
    step(32'd8456, 1'b1, 1'b0);
    step(32'd8456, 1'b0, 1'b0);
    // double injection
    step(32'hDEADBEEF, 1'b1, 1'b1);
    step(32'hFFFFFFFF, 1'b1, 1'b1);
    step(32'h00000000, 1'b0, 1'b1);
    step(32'h00000000, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++)
      step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(34'd0);

    for (int i = 0; i < 150; i++)
      step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(32'd0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);

    // single-error position sweep, word held for two edges
    for (int it = 0; it < 12; it++) begin
      d = $urandom;
      sweep_data = d;
      @(negedge clk);
      @(negedge clk);
      for (int p = 0; p < 39; p++) begin
        check_eq($sformatf("sweep_dec_%0d", p), 64'(sweep_dec[p]), 64'(d));
        check_eq($sformatf("sweep_flags_%0d", p), 64'({sweep_double[p], sweep_single[p]}), 64'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
